// File: rtl/fifo_read_drain_pkg.sv
// fifo_read_drain_pkg: shared types, default sizes and width helpers for the
// read-side drain stage.
package fifo_read_drain_pkg;

  // Drain controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_SIZE = 8;
  localparam int unsigned DEF_BUF_DEPTH = 2;
  localparam int unsigned DEF_CNT_W     = 16;

  // Occupancy width: must represent 0..depth inclusive
  function automatic int unsigned occ_w(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

  // Pointer width: indexes 0..depth-1
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : int'($clog2(depth));
  endfunction

  localparam int unsigned OCC_W = occ_w(DEF_BUF_DEPTH);
  localparam int unsigned PTR_W = ptr_w(DEF_BUF_DEPTH);

endpackage

// File: rtl/fifo_read_drain_if.sv
// fifo_read_drain_if: FIFO read port, output stream and control/status
// signals of the drain stage. master = drain stage, slave = surroundings.
interface fifo_read_drain_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_W     = 16
) ();
  logic                 drain_en;
  logic                 flush;
  logic                 fifo_rempty;
  logic [DATA_SIZE-1:0] fifo_rdata;
  logic                 fifo_rinc;
  logic                 m_valid;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_ready;
  logic                 busy;
  logic [CNT_W-1:0]     words_out;
  logic [CNT_W-1:0]     stall_cycles;

  modport master (
    input  drain_en, flush, fifo_rempty, fifo_rdata, m_ready,
    output fifo_rinc, m_valid, m_data, busy, words_out, stall_cycles
  );

  modport slave (
    output drain_en, flush, fifo_rempty, fifo_rdata, m_ready,
    input  fifo_rinc, m_valid, m_data, busy, words_out, stall_cycles
  );
endinterface

// File: rtl/fifo_read_drain_buffer.sv
// drain_buffer: circular output store for the drain stage. Clear wins over
// push/pop; head data comes straight from registered storage.
module drain_buffer
  import fifo_read_drain_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic [DATA_SIZE-1:0]          i_data,
  input  logic                          i_pop,
  input  logic                          i_clear,
  output logic [occ_w(BUF_DEPTH)-1:0]   o_occ,
  output logic [DATA_SIZE-1:0]          o_head
);
  localparam int unsigned PTR_WL = ptr_w(BUF_DEPTH);
  localparam int unsigned OCC_WL = occ_w(BUF_DEPTH);

  logic [DATA_SIZE-1:0] r_mem [BUF_DEPTH];
  logic [PTR_WL-1:0]    r_wr_ptr;
  logic [PTR_WL-1:0]    r_rd_ptr;
  logic [OCC_WL-1:0]    r_occ;

  function automatic logic [PTR_WL-1:0] ptr_inc(input logic [PTR_WL-1:0] p);
    return (p == PTR_WL'(BUF_DEPTH - 1)) ? '0 : p + PTR_WL'(1);
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_WL'(1);
        2'b01:   r_occ <= r_occ - OCC_WL'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_read_drain.sv
// fifo_read_drain: pops the async FIFO read port and re-presents the words
// as a valid/ready stream, covering the FIFO's one-cycle read latency with a
// small buffer. Optional statistics counters are built when RD_STATS_EN is
// defined; otherwise words_out/stall_cycles are tied to zero.
module fifo_read_drain
  import fifo_read_drain_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  fifo_read_drain_if.master bus
);
  localparam int unsigned OCC_WL = occ_w(BUF_DEPTH);
  localparam int unsigned LVL_W  = OCC_WL + 1;

  state_t               r_state;
  logic                 r_pend;
  logic [OCC_WL-1:0]    w_occ;
  logic [DATA_SIZE-1:0] w_head;
  logic                 w_valid;
  logic                 w_fire;
  logic                 w_clear;
  logic                 w_rinc;
  logic [LVL_W-1:0]     w_level;

  assign w_valid = (w_occ != '0);
  assign w_fire  = w_valid & bus.m_ready;
  // Flushing discards both buffered words and any word landing meanwhile
  assign w_clear = bus.flush | (r_state == FLUSH);
  // Projected fill once this cycle's landing and fire are applied
  assign w_level = LVL_W'(w_occ) + LVL_W'(r_pend) - LVL_W'(w_fire);
  assign w_rinc  = (r_state == RUN) & bus.drain_en & ~bus.fifo_rempty &
                   (w_level < LVL_W'(BUF_DEPTH));

  drain_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pend & ~w_clear),
    .i_data  (bus.fifo_rdata),
    .i_pop   (w_fire & ~w_clear),
    .i_clear (w_clear),
    .o_occ   (w_occ),
    .o_head  (w_head)
  );

  // Controller state and in-flight read tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_rinc;
      if (bus.flush) begin
        r_state <= FLUSH;
      end else begin
        case (r_state)
          IDLE:    if (bus.drain_en) r_state <= RUN;
          RUN:     if (!bus.drain_en) r_state <= IDLE;
          FLUSH:   if (!r_pend) r_state <= bus.drain_en ? RUN : IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_rinc = w_rinc;
  assign bus.m_valid   = w_valid;
  assign bus.m_data    = w_head;
  assign bus.busy      = w_valid | r_pend;

`ifdef RD_STATS_EN
  logic [CNT_W-1:0] r_words_out;
  logic [CNT_W-1:0] r_stall_cycles;

  // Saturating delivery and stall counters; only reset clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words_out    <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_fire && (r_words_out != '1))
        r_words_out <= r_words_out + CNT_W'(1);
      if (w_valid && !bus.m_ready && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign bus.words_out    = r_words_out;
  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.words_out    = '0;
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_read_drain.sv
// tb_fifo_read_drain: directed bench with a FIFO model and a scoreboard of
// popped words checked against delivered words.
module tb_fifo_read_drain;

`ifdef RD_STATS_EN
  localparam int unsigned CW       = 4;
  localparam int          STATS_ON = 1;
`else
  localparam int unsigned CW       = 16;
  localparam int          STATS_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_read_drain_if #(.DATA_SIZE(8), .CNT_W(CW)) bus ();

  fifo_read_drain #(
    .DATA_SIZE (8),
    .BUF_DEPTH (2),
    .CNT_W     (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors  = 0;
  int checks  = 0;
  int n_fired = 0;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  logic       s_rinc, s_valid, s_busy;
  logic [7:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at negedge, score fire/pop, then advance the FIFO model
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    s_rinc  = bus.fifo_rinc;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
    s_busy  = bus.busy;
    if (s_valid && bus.m_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      chk("sb_data", {24'h0, s_data}, {24'h0, e});
      n_fired++;
    end
    if (s_rinc) exp_q.push_back((fifo_q.size() != 0) ? fifo_q[0] : 8'hxx);
    @(posedge clk);
    #1;
    if (s_rinc && fifo_q.size() != 0) bus.fifo_rdata = fifo_q.pop_front();
    bus.fifo_rempty = (fifo_q.size() == 0);
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
    bus.fifo_rempty = (fifo_q.size() == 0);
  endtask

  // Run until FIFO, scoreboard and DUT are all idle, within a cycle budget
  task automatic drain(input string tag, input int limit, output int fired);
    int n0;
    logic done;
    n0   = n_fired;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !bus.busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    fired = n_fired - n0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int fired;

    bus.drain_en    = 1'b0;
    bus.flush       = 1'b0;
    bus.fifo_rempty = 1'b1;
    bus.fifo_rdata  = 8'h00;
    bus.m_ready     = 1'b1;

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_data",  32'(bus.m_data),  32'd0);
    chk("rst_busy",  32'(bus.busy),    32'd0);
    chk("rst_rinc",  32'(bus.fifo_rinc), 32'd0);
    chk("rst_words", 32'(bus.words_out), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Streaming: 16 words, no bubbles
    preload(8'h10, 16);
    bus.drain_en = 1'b1;
    tick();
    chk("t1_idle_rinc", 32'(s_rinc), 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t1_rinc",  32'(s_rinc),  32'((c <= 15) ? 1 : 0));
      chk("t1_valid", 32'(s_valid), 32'((c >= 2 && c <= 17) ? 1 : 0));
      if (c == 2) chk("t1_first", 32'(s_data), 32'h10);
    end
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: two reads then hold 0xA0
    bus.m_ready = 1'b0;
    preload(8'hA0, 6);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_rinc) cnt++;
      if (c >= 2) begin
        chk("t2_valid", 32'(s_valid), 32'd1);
        chk("t2_hold",  32'(s_data),  32'hA0);
      end
    end
    chk("t2_reads", 32'(cnt), 32'd2);
    chk("t2_rinc_low", 32'(s_rinc), 32'd0);
    bus.m_ready = 1'b1;
    drain("t2", 40, fired);
    chk("t2_fired", 32'(fired), 32'd6);

    // FIFO empties while the last read is pending
    preload(8'hB0, 3);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t3_busy",  32'(s_busy),  32'((c >= 1 && c <= 4) ? 1 : 0));
      chk("t3_valid", 32'(s_valid), 32'((c >= 2 && c <= 4) ? 1 : 0));
      if (c == 3) chk("t3_empty", 32'(bus.fifo_rempty), 32'd1);
      if (c == 4) chk("t3_last",  32'(s_data), 32'hB2);
    end
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with a word landing and another in flight
    preload(8'h30, 8);
    for (int c = 0; c < 4; c++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t4_fire_in_flush", 32'(s_valid), 32'd1);
    chk("t4_discards", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    tick();
    chk("t4_f1_valid", 32'(s_valid), 32'd0);
    chk("t4_f1_rinc",  32'(s_rinc),  32'd0);
    chk("t4_f1_busy",  32'(s_busy),  32'd1);
    tick();
    chk("t4_f2_valid", 32'(s_valid), 32'd0);
    chk("t4_f2_rinc",  32'(s_rinc),  32'd0);
    chk("t4_f2_busy",  32'(s_busy),  32'd0);
    tick();
    chk("t4_resume_rinc", 32'(s_rinc), 32'd1);
    tick();
    tick();
    chk("t4_next_valid", 32'(s_valid), 32'd1);
    chk("t4_next_data",  32'(s_data),  32'h35);
    drain("t4", 40, fired);
    chk("t4_after", 32'(fired), 32'd2);

    // Asynchronous reset mid-stream
    preload(8'h50, 8);
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(bus.m_valid),   32'd0);
    chk("t5_rinc",  32'(bus.fifo_rinc), 32'd0);
    chk("t5_busy",  32'(bus.busy),      32'd0);
    chk("t5_words", 32'(bus.words_out), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    bus.fifo_rempty = 1'b1;
    bus.fifo_rdata  = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    preload(8'h60, 3);
    tick();
    chk("t5_idle_rinc", 32'(s_rinc), 32'd0);
    tick();
    tick();
    tick();
    chk("t5_first", 32'(s_data), 32'h60);
    drain("t5", 30, fired);
    chk("t5_fired", 32'(fired), 32'd2);

    // Statistics: 20 fires since reset, then 3 stalled cycles
    preload(8'h70, 17);
    drain("t6", 60, fired);
    chk("t6_words", 32'(bus.words_out), 32'(STATS_ON ? 15 : 0));
    chk("t6_stall_zero", 32'(bus.stall_cycles), 32'd0);
    bus.m_ready = 1'b0;
    preload(8'h90, 1);
    for (int c = 0; c < 5; c++) tick();
    bus.m_ready = 1'b1;
    drain("t6b", 20, fired);
    chk("t6_stall", 32'(bus.stall_cycles), 32'(STATS_ON ? 3 : 0));
    chk("t6_words_sat", 32'(bus.words_out), 32'(STATS_ON ? 15 : 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
